// File: rtl/clock_pkg.sv
// Shared definitions for the hh:mm:ss clock controller: mode codes, BCD field limits
// and the BCD increment helper.
package clock_pkg;

  localparam logic [1:0] MODE_RUN    = 2'd0;
  localparam logic [1:0] MODE_SET_HH = 2'd1;
  localparam logic [1:0] MODE_SET_MM = 2'd2;
  localparam logic [1:0] MODE_SET_SS = 2'd3;

  localparam logic [7:0] HH_MAX = 8'h23;
  localparam logic [7:0] MS_MAX = 8'h59;

  // Limit check wins over digit rollover, so the result always stays in 00..max.
  function automatic logic [7:0] bcd_inc(input logic [7:0] val, input logic [7:0] max);
    logic [7:0] res;
    if (val == max) begin
      res = 8'h00;
    end else if (val[3:0] == 4'd9) begin
      res = {val[7:4] + 4'd1, 4'd0};
    end else begin
      res = {val[7:4], val[3:0] + 4'd1};
    end
    return res;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stability counter and a registered
// one-cycle pulse on each accepted press (release gives no pulse).
module btn_debounce #(
  parameter int unsigned DEB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press
);

  localparam int unsigned CW = $clog2(DEB_CYCLES + 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          level_prev_q;
  logic          press_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // The counter only runs while the synchronized input disagrees with the accepted level.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DEB_CYCLES - 1)) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      press_q      <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= btn_raw;
      sync2_q      <= sync1_q;
      level_q      <= level_d;
      level_prev_q <= level_q;
      press_q      <= level_q & ~level_prev_q;
      cnt_q        <= cnt_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/clock_ctrl.sv
// hh:mm:ss clock controller: 1 Hz prescaler, run/set mode FSM driven by two debounced
// buttons, and the BCD time registers feeding the display logic.
module clock_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 50_000_000,
  parameter int unsigned DEB_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [7:0] hh,
  output logic [7:0] mm,
  output logic [7:0] ss,
  output logic [1:0] mode,
  output logic       blink,
  output logic       tick_1hz
);

  localparam int unsigned PW = $clog2(TICK_DIV);

  logic          mode_press, inc_press;
  logic [1:0]    state_q, state_d;
  logic [PW-1:0] pres_q, pres_d;
  logic          tick_q, tick_d;
  logic          blink_q, blink_d;
  logic [7:0]    hh_q, hh_d, mm_q, mm_d, ss_q, ss_d;

  btn_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_deb_mode (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_mode),
    .press   (mode_press)
  );

  btn_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_deb_inc (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_inc),
    .press   (inc_press)
  );

  // Mode FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= MODE_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Mode FSM: next state
  always_comb begin
    state_d = state_q;
    if (mode_press) begin
      case (state_q)
        MODE_RUN:    state_d = MODE_SET_HH;
        MODE_SET_HH: state_d = MODE_SET_MM;
        MODE_SET_MM: state_d = MODE_SET_SS;
        default:     state_d = MODE_RUN;
      endcase
    end
  end

  // Mode FSM: outputs
  always_comb begin
    mode = state_q;
  end

  // tick and blink are registered from the next prescaler value so they line up with pres_q.
  always_comb begin
    if (pres_q == PW'(TICK_DIV - 1)) begin
      pres_d = '0;
    end else begin
      pres_d = pres_q + 1'b1;
    end
    if (mode_press && (state_q == MODE_SET_SS)) begin
      pres_d = '0;
    end
    tick_d  = (pres_d == PW'(TICK_DIV - 1));
    blink_d = (state_d != MODE_RUN) && (pres_d < PW'(TICK_DIV / 2));
  end

  always_comb begin
    hh_d = hh_q;
    mm_d = mm_q;
    ss_d = ss_q;
    if (state_q == MODE_RUN) begin
      if (tick_q) begin
        ss_d = bcd_inc(ss_q, MS_MAX);
        if (ss_q == MS_MAX) begin
          mm_d = bcd_inc(mm_q, MS_MAX);
          if (mm_q == MS_MAX) begin
            hh_d = bcd_inc(hh_q, HH_MAX);
          end
        end
      end
    end else if (inc_press && !mode_press) begin
      // A mode press in the same cycle wins; set-mode wraps never carry.
      case (state_q)
        MODE_SET_HH: hh_d = bcd_inc(hh_q, HH_MAX);
        MODE_SET_MM: mm_d = bcd_inc(mm_q, MS_MAX);
        default:     ss_d = bcd_inc(ss_q, MS_MAX);
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pres_q  <= '0;
      tick_q  <= 1'b0;
      blink_q <= 1'b0;
      hh_q    <= 8'h00;
      mm_q    <= 8'h00;
      ss_q    <= 8'h00;
    end else begin
      pres_q  <= pres_d;
      tick_q  <= tick_d;
      blink_q <= blink_d;
      hh_q    <= hh_d;
      mm_q    <= mm_d;
      ss_q    <= ss_d;
    end
  end

  assign hh       = hh_q;
  assign mm       = mm_q;
  assign ss       = ss_q;
  assign blink    = blink_q;
  assign tick_1hz = tick_q;

endmodule

// File: tb/tb_clock_ctrl.sv
// Self-checking bench for clock_ctrl with a fast prescaler and short debounce window.
module tb_clock_ctrl;

  localparam int unsigned TICK_DIV   = 10;
  localparam int unsigned DEB_CYCLES = 4;
  // Raw edge to press: 2 sync + DEB_CYCLES + 1; the field updates one cycle later.
  localparam int PRESS_LAT = 2 + DEB_CYCLES + 1 + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_mode, btn_inc;
  logic [7:0] hh, mm, ss;
  logic [1:0] mode;
  logic       blink, tick_1hz;

  int passed = 0;
  int total  = 0;

  clock_ctrl #(
    .TICK_DIV   (TICK_DIV),
    .DEB_CYCLES (DEB_CYCLES)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_mode (btn_mode),
    .btn_inc  (btn_inc),
    .hh       (hh),
    .mm       (mm),
    .ss       (ss),
    .mode     (mode),
    .blink    (blink),
    .tick_1hz (tick_1hz)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    cyc(2);
    rst = 1'b0;
  endtask

  task automatic press_btn(input bit is_mode, input int n);
    for (int i = 0; i < n; i++) begin
      if (is_mode) btn_mode = 1'b1;
      else btn_inc = 1'b1;
      cyc(PRESS_LAT + 1);
      btn_mode = 1'b0;
      btn_inc  = 1'b0;
      cyc(DEB_CYCLES + 4);
    end
  endtask

  task automatic test_reset();
    rst      = 1'b0;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    #3 rst = 1'b1;
    #1;
    total++;
    if ({hh, mm, ss} !== 24'h000000) $display("FAIL reset_time got %h want 000000", {hh, mm, ss});
    else passed++;
    total++;
    if ({mode, blink, tick_1hz} !== 4'b0000)
      $display("FAIL reset_ctrl got mode=%0d blink=%b tick=%b want 0 0 0", mode, blink, tick_1hz);
    else passed++;
  endtask

  task automatic test_run_count();
    do_reset();
    for (int c = 0; c <= 100; c++) begin
      if (c <= 10) begin
        total++;
        if (tick_1hz !== (c % TICK_DIV == TICK_DIV - 1))
          $display("FAIL run_tick cycle %0d got %b", c, tick_1hz);
        else passed++;
      end
      if (c == 10) begin
        total++;
        if ({hh, mm, ss, mode} !== {8'h00, 8'h00, 8'h01, 2'd0})
          $display("FAIL run_first_sec got %h:%h:%h mode %0d want 00:00:01 mode 0", hh, mm, ss, mode);
        else passed++;
      end
      if (c == 90 || c == 100) begin
        total++;
        if (ss !== to_bcd(c / TICK_DIV)) $display("FAIL run_bcd_carry cycle %0d got %h want %h",
                                                  c, ss, to_bcd(c / TICK_DIV));
        else passed++;
      end
      cyc(1);
    end
  endtask

  task automatic test_random_run();
    for (int r = 0; r < 3; r++) begin
      int k, sec;
      do_reset();
      k = int'($urandom_range(4000, 0));
      cyc(k);
      sec = k / TICK_DIV;
      total++;
      if ({hh, mm, ss} !== {to_bcd(sec / 3600), to_bcd((sec / 60) % 60), to_bcd(sec % 60)})
        $display("FAIL random_run k=%0d got %h:%h:%h want %0d s", k, hh, mm, ss, sec);
      else passed++;
      total++;
      if ({tick_1hz, blink} !== {(k % TICK_DIV == TICK_DIV - 1), 1'b0})
        $display("FAIL random_run_flags k=%0d got tick=%b blink=%b", k, tick_1hz, blink);
      else passed++;
    end
  endtask

  task automatic test_modes();
    int n, m, hi;
    do_reset();
    press_btn(1'b1, 1);
    total++;
    if (mode !== 2'd1) $display("FAIL mode_step1 got %0d want 1", mode);
    else passed++;
    hi = 0;
    for (int i = 0; i < int'(TICK_DIV); i++) begin
      hi += int'(blink);
      cyc(1);
    end
    cyc(15);
    total++;
    if (hi != int'(TICK_DIV / 2) || {hh, mm, ss} !== 24'h000000)
      $display("FAIL set_hh_hold blink_high=%0d time=%h want %0d and 000000", hi, {hh, mm, ss},
               TICK_DIV / 2);
    else passed++;
    n = int'($urandom_range(30, 23));
    press_btn(1'b0, n);
    total++;
    if ({hh, mm, ss} !== {to_bcd(n % 24), 16'h0000})
      $display("FAIL set_hh_wrap n=%0d got %h:%h:%h want %h:00:00", n, hh, mm, ss, to_bcd(n % 24));
    else passed++;
    press_btn(1'b1, 1);
    total++;
    if (mode !== 2'd2) $display("FAIL mode_step2 got %0d want 2", mode);
    else passed++;
    m = int'($urandom_range(64, 59));
    press_btn(1'b0, m);
    total++;
    if ({hh, mm, ss} !== {to_bcd(n % 24), to_bcd(m % 60), 8'h00})
      $display("FAIL set_mm_wrap m=%0d got %h:%h:%h", m, hh, mm, ss);
    else passed++;
    press_btn(1'b1, 1);
    hi = 0;
    for (int i = 0; i < int'(TICK_DIV); i++) begin
      hi += int'(blink);
      cyc(1);
    end
    total++;
    if (mode !== 2'd3 || hi != int'(TICK_DIV / 2))
      $display("FAIL mode_step3 got mode=%0d blink_high=%0d want 3 and %0d", mode, hi, TICK_DIV / 2);
    else passed++;
    press_btn(1'b1, 1);
    hi = 0;
    for (int i = 0; i < int'(TICK_DIV); i++) begin
      hi += int'(blink);
      cyc(1);
    end
    total++;
    if (mode !== 2'd0 || hi != 0) $display("FAIL mode_step0 got mode=%0d blink_high=%0d", mode, hi);
    else passed++;
  endtask

  task automatic test_debounce();
    int lat;
    do_reset();
    press_btn(1'b1, 1);
    for (int i = 0; i < 20; i++) begin
      btn_inc = (i % 2 == 0);
      cyc(2);
    end
    btn_inc = 1'b0;
    cyc(10);
    total++;
    if (hh !== 8'h00) $display("FAIL bounce_rejected got hh=%h want 00", hh);
    else passed++;
    btn_inc = 1'b1;
    lat = 0;
    while (hh === 8'h00 && lat < 30) begin
      cyc(1);
      lat++;
    end
    total++;
    if (lat != PRESS_LAT) $display("FAIL press_latency got %0d want %0d", lat, PRESS_LAT);
    else passed++;
    cyc(20);
    total++;
    if (hh !== 8'h01) $display("FAIL hold_single_press got hh=%h want 01", hh);
    else passed++;
    btn_inc = 1'b0;
    cyc(20);
    total++;
    if (hh !== 8'h01) $display("FAIL release_no_press got hh=%h want 01", hh);
    else passed++;
  endtask

  task automatic test_simultaneous();
    int k;
    do_reset();
    press_btn(1'b1, 2);
    k = int'($urandom_range(5, 1));
    press_btn(1'b0, k);
    btn_mode = 1'b1;
    btn_inc  = 1'b1;
    cyc(PRESS_LAT + 1);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    cyc(DEB_CYCLES + 4);
    total++;
    if (mode !== 2'd3 || mm !== to_bcd(k))
      $display("FAIL simultaneous got mode=%0d mm=%h want 3 and %h", mode, mm, to_bcd(k));
    else passed++;
  endtask

  task automatic test_rollover();
    int lat, cnt;
    do_reset();
    press_btn(1'b1, 1);
    press_btn(1'b0, 23);
    press_btn(1'b1, 1);
    press_btn(1'b0, 59);
    press_btn(1'b1, 1);
    press_btn(1'b0, 59);
    total++;
    if ({hh, mm, ss} !== 24'h235959) $display("FAIL load_235959 got %h:%h:%h", hh, mm, ss);
    else passed++;
    btn_mode = 1'b1;
    lat = 0;
    while (mode !== 2'd0 && lat < 30) begin
      cyc(1);
      lat++;
    end
    btn_mode = 1'b0;
    cnt = 0;
    while (tick_1hz !== 1'b1 && cnt < 30) begin
      cyc(1);
      cnt++;
    end
    // Mode change clears the prescaler, so the first tick lands TICK_DIV-1 cycles later.
    total++;
    if (lat >= 30 || cnt != int'(TICK_DIV) - 1)
      $display("FAIL tick_after_set got %0d cycles want %0d", cnt, TICK_DIV - 1);
    else passed++;
    total++;
    if ({hh, mm, ss} !== 24'h235959) $display("FAIL pre_wrap got %h:%h:%h", hh, mm, ss);
    else passed++;
    cyc(1);
    total++;
    if ({hh, mm, ss} !== 24'h000000) $display("FAIL day_wrap got %h:%h:%h want 00:00:00", hh, mm, ss);
    else passed++;
  endtask

  task automatic test_async_reset();
    do_reset();
    press_btn(1'b1, 1);
    press_btn(1'b0, 12);
    press_btn(1'b1, 1);
    press_btn(1'b0, 34);
    press_btn(1'b1, 1);
    press_btn(1'b0, 55);
    // The RUN dwell between presses is 17 cycles from a cleared prescaler: exactly one tick.
    press_btn(1'b1, 3);
    total++;
    if ({hh, mm, ss, mode} !== {24'h123456, 2'd2})
      $display("FAIL preload got %h:%h:%h mode %0d want 12:34:56 mode 2", hh, mm, ss, mode);
    else passed++;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if ({hh, mm, ss, mode, blink} !== 27'd0)
      $display("FAIL async_reset got %h:%h:%h mode %0d blink %b", hh, mm, ss, mode, blink);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    cyc(int'(TICK_DIV));
    total++;
    if ({hh, mm, ss} !== 24'h000001) $display("FAIL resume got %h:%h:%h want 00:00:01", hh, mm, ss);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_run_count();
    test_random_run();
    test_modes();
    test_debounce();
    test_simultaneous();
    test_rollover();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
